// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter that multiplexes consumer read/write request streams onto memory channels.
// Each channel holds its granted request until memory answers, then relays the response back.
module mem_channel_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

    // state      | meaning
    // IDLE       | channel free, may take a grant this cycle
    // READ_WAIT  | read request presented, waiting for mem_read_ready
    // WRITE_WAIT | write request presented, waiting for mem_write_ready
    // RELAY      | response held to the consumer until it drops its valid
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

    localparam int              OW     = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [OW:0]     NC     = (OW+1)'(NUM_CONSUMERS);
    localparam logic [OW-1:0]   LAST_C = OW'(NUM_CONSUMERS - 1);

    state_t                   state_q    [NUM_CHANNELS];
    state_t                   state_d    [NUM_CHANNELS];
    logic [OW-1:0]            owner_q    [NUM_CHANNELS];
    logic                     relay_wr_q [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] busy_q;
    logic [OW-1:0]            ptr_q;
    logic [OW-1:0]            ptr_d;

    logic [NUM_CONSUMERS-1:0] wr_req;
    logic [NUM_CONSUMERS-1:0] eligible;
    logic [NUM_CHANNELS-1:0]  grant;
    logic [OW-1:0]            grant_idx  [NUM_CHANNELS];
    logic                     grant_wr   [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] arb_taken;
    logic [OW:0]              arb_idx;
    logic                     arb_found;
    logic [OW-1:0]            arb_last;
    logic                     any_grant;

    assign wr_req   = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
    assign eligible = (consumer_read_valid | wr_req) & ~busy_q;

    // Channels allocate in ascending order; each scans upward from the pointer with wrap.
    always_comb begin
        arb_taken = '0;
        arb_idx   = '0;
        arb_found = 1'b0;
        arb_last  = ptr_q;
        any_grant = 1'b0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            grant[ch]     = 1'b0;
            grant_idx[ch] = '0;
            grant_wr[ch]  = 1'b0;
            arb_found     = 1'b0;
            if (state_q[ch] == IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    arb_idx = {1'b0, ptr_q} + (OW+1)'(k);
                    if (arb_idx >= NC) begin
                        arb_idx = arb_idx - NC;
                    end
                    if (!arb_found && eligible[arb_idx[OW-1:0]] && !arb_taken[arb_idx[OW-1:0]]) begin
                        arb_found                    = 1'b1;
                        grant[ch]                    = 1'b1;
                        grant_idx[ch]                = arb_idx[OW-1:0];
                        grant_wr[ch]                 = !consumer_read_valid[arb_idx[OW-1:0]];
                        arb_taken[arb_idx[OW-1:0]]   = 1'b1;
                        arb_last                     = arb_idx[OW-1:0];
                        any_grant                    = 1'b1;
                    end
                end
            end
        end
        ptr_d = ptr_q;
        if (any_grant) begin
            ptr_d = (arb_last == LAST_C) ? '0 : arb_last + 1'b1;
        end
    end

    always_comb begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_d[ch] = state_q[ch];
            case (state_q[ch])
                IDLE:       if (grant[ch]) state_d[ch] = grant_wr[ch] ? WRITE_WAIT : READ_WAIT;
                READ_WAIT:  if (mem_read_ready[ch]) state_d[ch] = RELAY;
                WRITE_WAIT: if (mem_write_ready[ch]) state_d[ch] = RELAY;
                RELAY: begin
                    if (relay_wr_q[ch] ? !consumer_write_valid[owner_q[ch]]
                                       : !consumer_read_valid[owner_q[ch]]) begin
                        state_d[ch] = IDLE;
                    end
                end
                default:    state_d[ch] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= IDLE;
            end
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= state_d[ch];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q               <= '0;
            ptr_q                <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= '0;
            mem_read_address     <= '0;
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                owner_q[ch]    <= '0;
                relay_wr_q[ch] <= 1'b0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (state_q[ch])
                    IDLE: begin
                        if (grant[ch]) begin
                            owner_q[ch]              <= grant_idx[ch];
                            relay_wr_q[ch]           <= grant_wr[ch];
                            busy_q[grant_idx[ch]]    <= 1'b1;
                            if (grant_wr[ch]) begin
                                if (WRITE_ENABLE != 0) begin
                                    mem_write_valid[ch] <= 1'b1;
                                    mem_write_address[ch*ADDR_BITS +: ADDR_BITS] <=
                                        consumer_write_address[int'(grant_idx[ch])*ADDR_BITS +: ADDR_BITS];
                                    mem_write_data[ch*DATA_BITS +: DATA_BITS] <=
                                        consumer_write_data[int'(grant_idx[ch])*DATA_BITS +: DATA_BITS];
                                end
                            end else begin
                                mem_read_valid[ch] <= 1'b1;
                                mem_read_address[ch*ADDR_BITS +: ADDR_BITS] <=
                                    consumer_read_address[int'(grant_idx[ch])*ADDR_BITS +: ADDR_BITS];
                            end
                        end
                    end
                    READ_WAIT: begin
                        if (mem_read_ready[ch]) begin
                            consumer_read_data[int'(owner_q[ch])*DATA_BITS +: DATA_BITS] <=
                                mem_read_data[ch*DATA_BITS +: DATA_BITS];
                            consumer_read_ready[owner_q[ch]] <= 1'b1;
                            mem_read_valid[ch]               <= 1'b0;
                        end
                    end
                    WRITE_WAIT: begin
                        if (mem_write_ready[ch] && (WRITE_ENABLE != 0)) begin
                            consumer_write_ready[owner_q[ch]] <= 1'b1;
                            mem_write_valid[ch]               <= 1'b0;
                        end
                    end
                    RELAY: begin
                        if (state_d[ch] == IDLE) begin
                            consumer_read_ready[owner_q[ch]]  <= 1'b0;
                            consumer_write_ready[owner_q[ch]] <= 1'b0;
                            busy_q[owner_q[ch]]               <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench for mem_channel_arbiter: single-channel, dual-channel and read-only instances.
module tb_mem_channel_arbiter;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    // Instance A: 4 consumers, 1 channel, writes enabled
    logic [3:0]  a_rv, a_rr, a_wv, a_wr;
    logic [31:0] a_ra, a_wa;
    logic [63:0] a_rd, a_wd;
    logic [0:0]  a_mrv, a_mrr, a_mwv, a_mwr;
    logic [7:0]  a_mra, a_mwa;
    logic [15:0] a_mrd, a_mwd;

    // Instance B: 4 consumers, 2 channels
    logic [3:0]  b_rv, b_rr, b_wv, b_wr;
    logic [31:0] b_ra, b_wa;
    logic [63:0] b_rd, b_wd;
    logic [1:0]  b_mrv, b_mrr, b_mwv, b_mwr;
    logic [15:0] b_mra, b_mwa;
    logic [31:0] b_mrd, b_mwd;

    // Instance C: read-only
    logic [3:0]  c_rv, c_rr, c_wv, c_wr;
    logic [31:0] c_ra, c_wa;
    logic [63:0] c_rd, c_wd;
    logic [0:0]  c_mrv, c_mrr, c_mwv, c_mwr;
    logic [7:0]  c_mra, c_mwa;
    logic [15:0] c_mrd, c_mwd;

    mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .WRITE_ENABLE(1)) dut_a (
        .clk(clk), .reset(rst_n),
        .consumer_read_valid(a_rv), .consumer_read_address(a_ra),
        .consumer_read_ready(a_rr), .consumer_read_data(a_rd),
        .consumer_write_valid(a_wv), .consumer_write_address(a_wa),
        .consumer_write_data(a_wd), .consumer_write_ready(a_wr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
        .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
    );

    mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2), .WRITE_ENABLE(1)) dut_b (
        .clk(clk), .reset(rst_n),
        .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
        .consumer_read_ready(b_rr), .consumer_read_data(b_rd),
        .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
        .consumer_write_data(b_wd), .consumer_write_ready(b_wr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
        .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
    );

    mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut_c (
        .clk(clk), .reset(rst_n),
        .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
        .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
        .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
        .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
        .mem_read_valid(c_mrv), .mem_read_address(c_mra),
        .mem_read_ready(c_mrr), .mem_read_data(c_mrd),
        .mem_write_valid(c_mwv), .mem_write_address(c_mwa),
        .mem_write_data(c_mwd), .mem_write_ready(c_mwr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_rv = '0; a_ra = '0; a_wv = '0; a_wa = '0; a_wd = '0; a_mrr = '0; a_mrd = '0; a_mwr = '0;
        b_rv = '0; b_ra = '0; b_wv = '0; b_wa = '0; b_wd = '0; b_mrr = '0; b_mrd = '0; b_mwr = '0;
        c_rv = '0; c_ra = '0; c_wv = '0; c_wa = '0; c_wd = '0; c_mrr = '0; c_mrd = '0; c_mwr = '0;
        repeat (2) @(negedge clk);
        tests_run++; if ({a_rr, a_wr, a_mrv, a_mwv} !== 10'd0) begin tests_failed++; $display("FAIL reset_ready_valid: got %b want 0", {a_rr, a_wr, a_mrv, a_mwv}); end
        tests_run++; if ({a_rd, a_mra, a_mwa, a_mwd} !== 96'd0) begin tests_failed++; $display("FAIL reset_data_addr: got %h want 0", {a_rd, a_mra, a_mwa, a_mwd}); end
        tests_run++; if ({b_mrv, b_mwv, b_rr, c_mrv, c_rr} !== 13'd0) begin tests_failed++; $display("FAIL reset_other_instances: got %b want 0", {b_mrv, b_mwv, b_rr, c_mrv, c_rr}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        // Stray memory ready while idle must be ignored
        a_mrr = 1'b1; a_mrd = 16'hDEAD;
        @(negedge clk);
        tests_run++; if ({a_rr, a_mrv} !== 5'd0) begin tests_failed++; $display("FAIL idle_ready_ignored: got %b want 0", {a_rr, a_mrv}); end
        a_mrr = 1'b0;
        a_ra[2*8 +: 8] = 8'h10; a_rv = 4'b0100;
        @(negedge clk);
        tests_run++; if (a_mrv !== 1'b1) begin tests_failed++; $display("FAIL single_mem_valid: got %b want 1", a_mrv); end
        tests_run++; if (a_mra !== 8'h10) begin tests_failed++; $display("FAIL single_mem_addr: got %h want 10", a_mra); end
        tests_run++; if (a_rr !== 4'b0000) begin tests_failed++; $display("FAIL single_early_ready: got %b want 0000", a_rr); end
        a_mrr = 1'b1; a_mrd = 16'hBEEF;
        @(negedge clk);
        a_mrr = 1'b0;
        tests_run++; if (a_rr !== 4'b0100) begin tests_failed++; $display("FAIL single_ready: got %b want 0100", a_rr); end
        tests_run++; if (a_rd[2*16 +: 16] !== 16'hBEEF) begin tests_failed++; $display("FAIL single_data: got %h want BEEF", a_rd[2*16 +: 16]); end
        tests_run++; if (a_mrv !== 1'b0) begin tests_failed++; $display("FAIL single_mem_valid_drop: got %b want 0", a_mrv); end
        @(negedge clk);
        tests_run++; if (a_rr !== 4'b0100) begin tests_failed++; $display("FAIL single_ready_hold: got %b want 0100", a_rr); end
        a_rv = 4'b0000;
        @(negedge clk);
        tests_run++; if (a_rr !== 4'b0000) begin tests_failed++; $display("FAIL single_ready_fall: got %b want 0000", a_rr); end
        tests_run++; if (a_rd[2*16 +: 16] !== 16'hBEEF) begin tests_failed++; $display("FAIL single_data_hold: got %h want BEEF", a_rd[2*16 +: 16]); end
        @(negedge clk);
    endtask

    task automatic test_read_priority();
        a_ra[1*8 +: 8] = 8'h61; a_wa[1*8 +: 8] = 8'h62; a_wd[1*16 +: 16] = 16'h0A0A;
        a_rv = 4'b0010; a_wv = 4'b0010;
        @(negedge clk);
        tests_run++; if ({a_mrv, a_mwv} !== 2'b10) begin tests_failed++; $display("FAIL prio_read_first: got %b want 10", {a_mrv, a_mwv}); end
        tests_run++; if (a_mra !== 8'h61) begin tests_failed++; $display("FAIL prio_read_addr: got %h want 61", a_mra); end
        a_mrr = 1'b1; a_mrd = 16'h6161;
        @(negedge clk);
        a_mrr = 1'b0;
        tests_run++; if (a_rr !== 4'b0010) begin tests_failed++; $display("FAIL prio_read_ready: got %b want 0010", a_rr); end
        a_rv = 4'b0000;
        @(negedge clk);
        tests_run++; if ({a_rr, a_mwv} !== 5'd0) begin tests_failed++; $display("FAIL prio_relay_exit: got %b want 0", {a_rr, a_mwv}); end
        @(negedge clk);
        tests_run++; if (a_mwv !== 1'b1) begin tests_failed++; $display("FAIL prio_write_later: got %b want 1", a_mwv); end
        tests_run++; if ({a_mwa, a_mwd} !== 24'h620A0A) begin tests_failed++; $display("FAIL prio_write_payload: got %h want 620A0A", {a_mwa, a_mwd}); end
        a_mwr = 1'b1;
        @(negedge clk);
        a_mwr = 1'b0;
        tests_run++; if (a_wr !== 4'b0010) begin tests_failed++; $display("FAIL prio_write_ready: got %b want 0010", a_wr); end
        a_wv = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_write();
        a_wa[0 +: 8] = 8'h20; a_wd[0 +: 16] = 16'h0055; a_wv = 4'b0001;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            tests_run++; if ({a_mwv, a_mwa, a_mwd} !== {1'b1, 8'h20, 16'h0055}) begin tests_failed++; $display("FAIL write_hold_cycle%0d: got %h want 1200055", d, {a_mwv, a_mwa, a_mwd}); end
            tests_run++; if (a_wr !== 4'b0000) begin tests_failed++; $display("FAIL write_early_ready_cycle%0d: got %b want 0000", d, a_wr); end
            if (d == 2) a_mwr = 1'b1;
            @(negedge clk);
        end
        a_mwr = 1'b0;
        tests_run++; if (a_wr !== 4'b0001) begin tests_failed++; $display("FAIL write_ready: got %b want 0001", a_wr); end
        tests_run++; if (a_mwv !== 1'b0) begin tests_failed++; $display("FAIL write_valid_drop: got %b want 0", a_mwv); end
        a_wv = 4'b0000;
        @(negedge clk);
        tests_run++; if (a_wr !== 4'b0000) begin tests_failed++; $display("FAIL write_ready_fall: got %b want 0000", a_wr); end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [7:0] exp_a;
        int         cnt;
        apply_reset();
        for (int i = 0; i < 4; i++) a_ra[i*8 +: 8] = 8'h40 + 8'(i);
        a_rv = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % 4;
            exp_a = 8'h40 + 8'(e);
            cnt = 0;
            while (a_mrv !== 1'b1 && cnt < 10) begin
                @(negedge clk);
                cnt++;
            end
            tests_run++; if (cnt >= 10) begin tests_failed++; $display("FAIL fair_grant%0d_timeout: got no mem_read_valid want valid within 10 cycles", g); end
            tests_run++; if (a_mra !== exp_a) begin tests_failed++; $display("FAIL fair_grant%0d_order: got addr %h want %h", g, a_mra, exp_a); end
            a_mrd = {8'hD0, exp_a}; a_mrr = 1'b1;
            @(negedge clk);
            a_mrr = 1'b0;
            tests_run++; if (a_rr !== (4'b0001 << e)) begin tests_failed++; $display("FAIL fair_grant%0d_ready: got %b want %b", g, a_rr, 4'b0001 << e); end
            tests_run++; if (a_rd[e*16 +: 16] !== {8'hD0, exp_a}) begin tests_failed++; $display("FAIL fair_grant%0d_data: got %h want %h", g, a_rd[e*16 +: 16], {8'hD0, exp_a}); end
            a_rv[e] = 1'b0;
            @(negedge clk);
            if (g == 4) a_rv = 4'b0000;
            else        a_rv[e] = 1'b1;
        end
        repeat (2) @(negedge clk);
        tests_run++; if ({a_mrv, a_rr} !== 5'd0) begin tests_failed++; $display("FAIL fair_quiet: got %b want 0", {a_mrv, a_rr}); end
    endtask

    task automatic test_multi_channel();
        b_ra[1*8 +: 8] = 8'h31; b_ra[3*8 +: 8] = 8'h33;
        b_rv = 4'b1010;
        @(negedge clk);
        tests_run++; if (b_mrv !== 2'b11) begin tests_failed++; $display("FAIL multi_both_valid: got %b want 11", b_mrv); end
        tests_run++; if (b_mra !== 16'h3331) begin tests_failed++; $display("FAIL multi_channel_addrs: got %h want 3331", b_mra); end
        b_mrr = 2'b11; b_mrd = 32'h3333_1111;
        @(negedge clk);
        b_mrr = 2'b00;
        tests_run++; if (b_rr !== 4'b1010) begin tests_failed++; $display("FAIL multi_ready: got %b want 1010", b_rr); end
        tests_run++; if ({b_rd[3*16 +: 16], b_rd[1*16 +: 16]} !== 32'h3333_1111) begin tests_failed++; $display("FAIL multi_data: got %h want 33331111", {b_rd[3*16 +: 16], b_rd[1*16 +: 16]}); end
        tests_run++; if (b_mrv !== 2'b00) begin tests_failed++; $display("FAIL multi_valid_drop: got %b want 00", b_mrv); end
        b_rv = 4'b0000;
        @(negedge clk);
        tests_run++; if (b_rr !== 4'b0000) begin tests_failed++; $display("FAIL multi_ready_fall: got %b want 0000", b_rr); end
        @(negedge clk);
        tests_run++; if (b_mrv !== 2'b00) begin tests_failed++; $display("FAIL multi_no_regrant: got %b want 00", b_mrv); end
    endtask

    task automatic test_write_disable();
        c_wv = 4'b1111; c_wa = 32'h1122_3344; c_wd = 64'h1111_2222_3333_4444;
        c_ra[2*8 +: 8] = 8'h77; c_rv = 4'b0100;
        @(negedge clk);
        tests_run++; if ({c_mrv, c_mra} !== {1'b1, 8'h77}) begin tests_failed++; $display("FAIL wdis_read_grant: got %h want 177", {c_mrv, c_mra}); end
        tests_run++; if ({c_mwv, c_wr} !== 5'd0) begin tests_failed++; $display("FAIL wdis_no_write_at_grant: got %b want 0", {c_mwv, c_wr}); end
        c_mrr = 1'b1; c_mrd = 16'h7777; c_mwr = 1'b1;
        @(negedge clk);
        c_mrr = 1'b0;
        tests_run++; if (c_rr !== 4'b0100) begin tests_failed++; $display("FAIL wdis_read_ready: got %b want 0100", c_rr); end
        tests_run++; if (c_rd[2*16 +: 16] !== 16'h7777) begin tests_failed++; $display("FAIL wdis_read_data: got %h want 7777", c_rd[2*16 +: 16]); end
        c_rv = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++; if ({c_mwv, c_wr, c_mwa, c_mwd, c_mrv} !== 30'd0) begin tests_failed++; $display("FAIL wdis_idle_cycle%0d: got %h want 0", i, {c_mwv, c_wr, c_mwa, c_mwd, c_mrv}); end
        end
        c_wv = 4'b0000; c_mwr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        a_ra[0 +: 8] = 8'h10; a_rv = 4'b0001;
        @(negedge clk);
        tests_run++; if (a_mrv !== 1'b1) begin tests_failed++; $display("FAIL rmid_in_read_wait: got %b want 1", a_mrv); end
        #2 rst_n = 1'b0;
        a_rv = 4'b0000; a_mrr = 1'b1; a_mrd = 16'hBAD0;
        #1;
        tests_run++; if ({a_mrv, a_mra, a_rr} !== 13'd0) begin tests_failed++; $display("FAIL rmid_async_clear: got %h want 0", {a_mrv, a_mra, a_rr}); end
        tests_run++; if (a_rd !== 64'd0) begin tests_failed++; $display("FAIL rmid_data_clear: got %h want 0", a_rd); end
        @(negedge clk);
        rst_n = 1'b1; a_mrr = 1'b0;
        @(negedge clk);
        tests_run++; if ({a_rr, a_mrv} !== 5'd0) begin tests_failed++; $display("FAIL rmid_aborted: got %b want 0", {a_rr, a_mrv}); end
        a_rv = 4'b0001;
        @(negedge clk);
        tests_run++; if ({a_mrv, a_mra} !== {1'b1, 8'h10}) begin tests_failed++; $display("FAIL rmid_regrant: got %h want 110", {a_mrv, a_mra}); end
        a_mrr = 1'b1; a_mrd = 16'h1234;
        @(negedge clk);
        a_mrr = 1'b0;
        tests_run++; if ({a_rr, a_rd[0 +: 16]} !== {4'b0001, 16'h1234}) begin tests_failed++; $display("FAIL rmid_fresh_data: got %h want 11234", {a_rr, a_rd[0 +: 16]}); end
        a_rv = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single_read();
        test_read_priority();
        test_write();
        test_fairness();
        test_multi_channel();
        test_write_disable();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_channel_arbiter.md
Name: mem_channel_arbiter

Overview:
- Sits between the per-thread LSUs (or per-core fetchers) and the external asynchronous memory channels, directly downstream of the core array.
- Multiplexes NUM_CONSUMERS valid/ready request streams onto NUM_CHANNELS memory channels with fair round-robin arbitration.
- Holds each granted request on its channel until memory responds, then relays the response back to the consumer under a 4-phase handshake.

Parameters:
- ADDR_BITS, 8, memory address width
- DATA_BITS, 16, memory data width
- NUM_CONSUMERS, 4, number of requesters (LSUs or fetchers)
- NUM_CHANNELS, 1, number of concurrent memory channels; must be ≤ NUM_CONSUMERS
- WRITE_ENABLE, 1, 0 = read-only instance; write logic removed

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  consumer i at [i*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  out  NUM_CONSUMERS  read data valid for consumer i
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  consumer i at [i*DATA_BITS +: DATA_BITS]
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  write address
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  write data
- consumer_write_ready  out  NUM_CONSUMERS  write completed for consumer i
- mem_read_valid  out  NUM_CHANNELS  channel read request
- mem_read_address  out  NUM_CHANNELS*ADDR_BITS  channel read address
- mem_read_ready  in  NUM_CHANNELS  memory read data valid
- mem_read_data  in  NUM_CHANNELS*DATA_BITS  memory read data
- mem_write_valid  out  NUM_CHANNELS  channel write request
- mem_write_address  out  NUM_CHANNELS*ADDR_BITS  channel write address
- mem_write_data  out  NUM_CHANNELS*DATA_BITS  channel write data
- mem_write_ready  in  NUM_CHANNELS  memory write acknowledge

Behaviour:
- Reset (reset low, asynchronous): all outputs 0; all channels IDLE; busy mask 0; round-robin pointer 0. Any in-flight transaction is aborted and no response is delivered.
- Per-channel FSM states: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- Eligibility: consumer i is eligible if (read_valid[i] or, when WRITE_ENABLE=1, write_valid[i]) and busy[i]=0.
- Arbitration: each cycle, IDLE channels are allocated in ascending channel index. Each takes the first eligible consumer found scanning upward from the pointer with wrap-around. No consumer is granted to two channels in the same cycle. When at least one grant occurs, the pointer moves to (last granted index + 1) mod NUM_CONSUMERS; otherwise it is unchanged.
- Grant on cycle N: latch address (and data), set busy[i], assert mem_*_valid from cycle N+1.
  - Read has priority if consumer i asserts both read and write; the write is served on a later grant.
- READ_WAIT: on mem_read_ready, at the next edge:
  - latch mem_read_data into consumer_read_data slot i;
  - consumer_read_ready[i]=1;
  - mem_read_valid=0;
  - go to RELAY.
- WRITE_WAIT: on mem_write_ready, at the next edge: consumer_write_ready[i]=1; mem_write_valid=0; go to RELAY.
- RELAY: hold ready until the consumer drops the corresponding valid. At the next edge: ready=0, clear busy[i], go to IDLE. The consumer may be re-granted from the cycle after that.
- Latency: read with 1-cycle memory gives valid at N, mem valid at N+1, mem ready at N+1, consumer ready at N+2. Minimum inter-request spacing for one consumer is 4 cycles.
- mem_*_ready while the channel is not waiting is ignored.
- Consumer dropping valid during READ_WAIT/WRITE_WAIT does not cancel the transaction; it completes normally and RELAY exits immediately.
- consumer_read_data slot i holds its last value until overwritten.
- WRITE_ENABLE=0: consumer_write_ready and mem_write_* are tied to 0; write inputs are ignored.
- No arithmetic besides the pointer increment, which wraps modulo NUM_CONSUMERS.

Test Plan:
- Reset mid-read: assert reset low while channel 0 is in READ_WAIT -> all outputs 0 asynchronously; after release, the consumer must re-request and is served with fresh data.
- Single read (C=4, CH=1, 1-cycle memory): consumer 2 reads addr 0x10, mem returns 0xBEEF -> mem_read_valid at N+1 with address 0x10; consumer_read_ready[2]=1 with data 0xBEEF at N+2; ready falls 1 cycle after valid drops.
- Fairness: all 4 consumers hold read_valid, CH=1 -> grant order 0,1,2,3,0; no consumer is granted twice before the others.
- Multi-channel (CH=2): consumers 1 and 3 request in the same cycle -> channel 0 serves 1, channel 1 serves 3, both with mem valid on the next cycle; consumer 1 is never on both channels.
- Write path: consumer 0 writes 0x55 to 0x20, mem_write_ready delayed 3 cycles -> mem_write_valid/address/data held stable for all 3 cycles; consumer_write_ready[0] rises the cycle after ack.
- WRITE_ENABLE=0: write_valid on all consumers -> mem_write_valid stays 0 and consumer_write_ready stays 0 indefinitely; concurrent reads are unaffected.
